// File: rtl/vga_output_stage.sv
// -----------------------------------------------------------------------------
// vga_output_stage
// Registered VGA DAC output stage. It expands IN_W-bit colour to OUT_W-bit DAC
// colour by cyclic bit replication and forces colour to zero outside active
// video. It can replace the pixel stream with an internal test pattern
// (passthrough, colour bars, checkerboard, black). Colour, sync and blank all
// travel through the same PIPE-deep register chain, so they stay aligned.
//
// Ports:
//   clk, rst               pixel clock, synchronous active-high reset
//   R, G, B [IN_W]         input pixel colour
//   HSYNC, VSYNC           input syncs (active-low when SYNC_IN_LOW = 1)
//   VDO_OUT                active-video flag, high = visible pixel
//   MODE [2]               requested pattern mode, taken at frame start only
//   VGA_R/G/B [OUT_W]      DAC colour, PIPE cycles after the input
//   VGA_HSYNC, VGA_VSYNC   delayed syncs, optionally inverted
//   VGA_CLK                copy of clk
//   VGA_BLANK_N            delayed VDO_OUT
//   VGA_SYNC_N             tied low
//   MODE_ACT [2]           pattern mode currently in effect
// -----------------------------------------------------------------------------
module vga_output_stage #(
   parameter int IN_W        = 4,
   parameter int OUT_W       = 8,
   parameter int PIPE        = 2,
   parameter bit SYNC_IN_LOW = 1'b1,
   parameter bit INVERT_SYNC = 1'b0,
   parameter int BAR_W       = 80,
   parameter int CK_LOG2     = 5,
   parameter int X_W         = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  R,
   input  logic [IN_W-1:0]  G,
   input  logic [IN_W-1:0]  B,
   input  logic             HSYNC,
   input  logic             VSYNC,
   input  logic             VDO_OUT,
   input  logic [1:0]       MODE,
   output logic [OUT_W-1:0] VGA_R,
   output logic [OUT_W-1:0] VGA_G,
   output logic [OUT_W-1:0] VGA_B,
   output logic             VGA_HSYNC,
   output logic             VGA_VSYNC,
   output logic             VGA_CLK,
   output logic             VGA_BLANK_N,
   output logic             VGA_SYNC_N,
   output logic [1:0]       MODE_ACT
);

   localparam int               SW       = 3 * OUT_W + 3;
   // Inactive output sync level: inactive input level, optionally inverted.
   localparam logic             SYNC_RST = SYNC_IN_LOW ^ INVERT_SYNC;
   localparam logic [SW-1:0]    RST_WORD = {{(3 * OUT_W){1'b0}}, SYNC_RST, SYNC_RST, 1'b0};
   localparam logic [X_W-1:0]   CNT_MAX  = '1;
   localparam logic [X_W-1:0]   CNT_ONE  = X_W'(1);
   localparam logic [OUT_W-1:0] FULL     = '1;

   logic [X_W-1:0]   x_q, x_d, y_q, y_d;
   logic             vdo_prev_q, vdo_prev_d;
   logic             vs_prev_q, vs_prev_d;
   logic [1:0]       mode_q, mode_d;
   logic             vs_act;
   logic [OUT_W-1:0] r_exp, g_exp, b_exp;
   logic [OUT_W-1:0] r_pix, g_pix, b_pix;
   logic [6:0]       bar_ge;
   logic [2:0]       bar_k;
   logic             ck_dark;
   logic [SW-1:0]    stage_in;
   logic [SW-1:0]    pipe_q [PIPE];
   logic [SW-1:0]    pipe_d [PIPE];

   // Cyclic replication: output bit i takes input bit
   // IN_W-1 - ((OUT_W-1-i) mod IN_W), i.e. the input repeated from the MSB down.
   generate
      for (genvar gi = 0; gi < OUT_W; gi++) begin : g_expand
         localparam int SRC = IN_W - 1 - ((OUT_W - 1 - gi) % IN_W);
         assign r_exp[gi] = R[SRC];
         assign g_exp[gi] = G[SRC];
         assign b_exp[gi] = B[SRC];
      end
      // Bar index as a thermometer of x >= j*BAR_W, which avoids a divider and
      // saturates at 7 on its own.
      for (genvar gi = 1; gi < 8; gi++) begin : g_bar
         localparam logic [63:0] TH = 64'(gi * BAR_W);
         assign bar_ge[gi-1] = (64'(x_q) >= TH);
      end
   endgenerate

   always_comb begin
      bar_k = '0;
      for (int j = 0; j < 7; j++) begin
         bar_k = bar_k + {2'b00, bar_ge[j]};
      end
   end

   assign ck_dark = x_q[CK_LOG2] ^ y_q[CK_LOG2];

   // Counters and frame-start mode latch.
   always_comb begin
      vs_act     = SYNC_IN_LOW ? ~VSYNC : VSYNC;
      x_d        = '0;
      if (VDO_OUT) begin
         x_d = (x_q == CNT_MAX) ? x_q : x_q + CNT_ONE;
      end
      y_d = y_q;
      if (vdo_prev_q && !VDO_OUT && (y_q != CNT_MAX)) begin
         y_d = y_q + CNT_ONE;
      end
      // Vertical sync clears the line count even on an end-of-line cycle.
      if (vs_act) begin
         y_d = '0;
      end
      mode_d     = (vs_act && !vs_prev_q) ? MODE : mode_q;
      vdo_prev_d = VDO_OUT;
      vs_prev_d  = vs_act;
   end

   // Pixel colour for this cycle, using the counters before they advance.
   always_comb begin
      r_pix = '0;
      g_pix = '0;
      b_pix = '0;
      if (VDO_OUT) begin
         case (mode_q)
            2'd0: begin
               r_pix = r_exp;
               g_pix = g_exp;
               b_pix = b_exp;
            end
            2'd1: begin
               r_pix = bar_k[1] ? '0 : FULL;
               g_pix = bar_k[2] ? '0 : FULL;
               b_pix = bar_k[0] ? '0 : FULL;
            end
            2'd2: begin
               r_pix = ck_dark ? '0 : FULL;
               g_pix = ck_dark ? '0 : FULL;
               b_pix = ck_dark ? '0 : FULL;
            end
            default: begin
               r_pix = '0;
               g_pix = '0;
               b_pix = '0;
            end
         endcase
      end
   end

   assign stage_in = {r_pix, g_pix, b_pix,
                      HSYNC ^ INVERT_SYNC, VSYNC ^ INVERT_SYNC, VDO_OUT};

   always_comb begin
      pipe_d[0] = stage_in;
      for (int i = 1; i < PIPE; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q        <= '0;
         y_q        <= '0;
         vdo_prev_q <= 1'b0;
         vs_prev_q  <= 1'b0;
         mode_q     <= 2'd0;
         for (int i = 0; i < PIPE; i++) begin
            pipe_q[i] <= RST_WORD;
         end
      end else begin
         x_q        <= x_d;
         y_q        <= y_d;
         vdo_prev_q <= vdo_prev_d;
         vs_prev_q  <= vs_prev_d;
         mode_q     <= mode_d;
         for (int i = 0; i < PIPE; i++) begin
            pipe_q[i] <= pipe_d[i];
         end
      end
   end

   assign {VGA_R, VGA_G, VGA_B, VGA_HSYNC, VGA_VSYNC, VGA_BLANK_N} = pipe_q[PIPE-1];
   assign VGA_CLK    = clk;
   assign VGA_SYNC_N = 1'b0;
   assign MODE_ACT   = mode_q;

endmodule

// File: tb/tb_vga_output_stage.sv
`timescale 1ns/1ps
module tb_vga_output_stage;

   // dut_a: IN_W=4, PIPE=2, syncs not inverted.
   // dut_b: IN_W=5, PIPE=3, syncs inverted. Both see the same stimulus.
   localparam int HN = 32768;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic       hs;
      logic       vs;
      logic       bl;
   } out_t;

   typedef struct {
      logic [4:0] r;
      logic       vdo;
      logic [7:0] exp_a;
      logic [7:0] exp_b;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] r_in = '0, g_in = '0, b_in = '0;
   logic       hsync = 1'b1, vsync = 1'b1, vdo = 1'b0;
   logic [1:0] mode = 2'd0;

   logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;
   logic       a_hs, a_vs, a_clk, a_bl, a_sn, b_hs, b_vs, b_clk, b_bl, b_sn;
   logic [1:0] a_mact, b_mact;

   vga_output_stage #(.IN_W(4), .OUT_W(8), .PIPE(2), .SYNC_IN_LOW(1'b1), .INVERT_SYNC(1'b0),
                      .BAR_W(80), .CK_LOG2(5), .X_W(12)) dut_a (
      .clk(clk), .rst(rst), .R(r_in[3:0]), .G(g_in[3:0]), .B(b_in[3:0]),
      .HSYNC(hsync), .VSYNC(vsync), .VDO_OUT(vdo), .MODE(mode),
      .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b), .VGA_HSYNC(a_hs), .VGA_VSYNC(a_vs),
      .VGA_CLK(a_clk), .VGA_BLANK_N(a_bl), .VGA_SYNC_N(a_sn), .MODE_ACT(a_mact));

   vga_output_stage #(.IN_W(5), .OUT_W(8), .PIPE(3), .SYNC_IN_LOW(1'b1), .INVERT_SYNC(1'b1),
                      .BAR_W(80), .CK_LOG2(5), .X_W(12)) dut_b (
      .clk(clk), .rst(rst), .R(r_in), .G(g_in), .B(b_in),
      .HSYNC(hsync), .VSYNC(vsync), .VDO_OUT(vdo), .MODE(mode),
      .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .VGA_HSYNC(b_hs), .VGA_VSYNC(b_vs),
      .VGA_CLK(b_clk), .VGA_BLANK_N(b_bl), .VGA_SYNC_N(b_sn), .MODE_ACT(b_mact));

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   out_t hist_a [HN];
   out_t hist_b [HN];
   int   cyc = 4;
   int   mx = 0, my = 0, mmode = 0;
   bit   pvdo = 0, pvs = 0;
   int   n_chk = 0, n_fail = 0;
   int   bar_tab [8];   // colour per bar as {R,G,B} bits

   // Repeat the input word end to end and keep the top 8 bits.
   function automatic int expand(int v, int w);
      longint acc = 0;
      int     bits = 0;
      while (bits < 8) begin
         acc  = (acc << w) | longint'(v);
         bits = bits + w;
      end
      return int'((acc >> (bits - 8)) & 255);
   endfunction

   function automatic out_t model_out(int w, bit inv);
      out_t o;
      int   rr = 0, gg = 0, bb = 0, k, m, c;
      if (vdo) begin
         case (mmode)
            0: begin
               m  = (1 << w) - 1;
               rr = expand(int'(r_in) & m, w);
               gg = expand(int'(g_in) & m, w);
               bb = expand(int'(b_in) & m, w);
            end
            1: begin
               k = mx / 80;
               if (k > 7) k = 7;
               c  = bar_tab[k];
               rr = ((c >> 2) & 1) ? 255 : 0;
               gg = ((c >> 1) & 1) ? 255 : 0;
               bb = (c & 1) ? 255 : 0;
            end
            2: begin
               c  = (((mx >> 5) ^ (my >> 5)) & 1) ? 0 : 255;
               rr = c; gg = c; bb = c;
            end
            default: begin
               rr = 0; gg = 0; bb = 0;
            end
         endcase
      end
      o.r  = 8'(rr);
      o.g  = 8'(gg);
      o.b  = 8'(bb);
      o.hs = hsync ^ inv;
      o.vs = vsync ^ inv;
      o.bl = vdo;
      return o;
   endfunction

   task automatic model_step();
      bit   vs_act;
      out_t ra, rb;
      if (rst) begin
         ra = '{r: 8'd0, g: 8'd0, b: 8'd0, hs: 1'b1, vs: 1'b1, bl: 1'b0};
         rb = '{r: 8'd0, g: 8'd0, b: 8'd0, hs: 1'b0, vs: 1'b0, bl: 1'b0};
         // Reset loads every pipeline stage at once.
         for (int k = 0; k < 3; k++) begin
            hist_a[cyc-k] = ra;
            hist_b[cyc-k] = rb;
         end
         mx = 0; my = 0; mmode = 0; pvdo = 0; pvs = 0;
      end else begin
         hist_a[cyc] = model_out(4, 1'b0);
         hist_b[cyc] = model_out(5, 1'b1);
         vs_act = !vsync;
         if (vs_act) my = 0;
         else if (pvdo && !vdo && my < 4095) my = my + 1;
         if (vs_act && !pvs) mmode = int'(mode);
         mx   = vdo ? ((mx < 4095) ? mx + 1 : mx) : 0;
         pvdo = vdo;
         pvs  = vs_act;
      end
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      out_t ea, eb;
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
      ea = hist_a[cyc-1];   // PIPE 2
      eb = hist_b[cyc-2];   // PIPE 3
      check("a_colour", {8'd0, a_r, a_g, a_b}, {8'd0, ea.r, ea.g, ea.b});
      check("a_sync_blank", {29'd0, a_hs, a_vs, a_bl}, {29'd0, ea.hs, ea.vs, ea.bl});
      check("b_colour", {8'd0, b_r, b_g, b_b}, {8'd0, eb.r, eb.g, eb.b});
      check("b_sync_blank", {29'd0, b_hs, b_vs, b_bl}, {29'd0, eb.hs, eb.vs, eb.bl});
      check("mode_act", {28'd0, a_mact, b_mact}, {28'd0, 2'(mmode), 2'(mmode)});
      check("sync_n_clk", {28'd0, a_sn, b_sn, a_clk, b_clk}, 32'd0);
      cyc++;
   endtask

   // Active pixels with random colour, then blanking with an hsync pulse.
   task automatic line(int n_act, int n_blank, int hs_start, int hs_len);
      vdo = 1'b1;
      for (int i = 0; i < n_act; i++) begin
         r_in = 5'($urandom); g_in = 5'($urandom); b_in = 5'($urandom);
         tick();
      end
      vdo = 1'b0;
      for (int i = 0; i < n_blank; i++) begin
         hsync = !(i >= hs_start && i < hs_start + hs_len);
         tick();
      end
      hsync = 1'b1;
   endtask

   task automatic frame_start();
      vsync = 1'b0;
      line(0, 40, 4, 8);
      line(0, 40, 4, 8);
      vsync = 1'b1;
   endtask

   vec_t vecs [6];

   initial begin
      bar_tab[0] = 7; bar_tab[1] = 6; bar_tab[2] = 3; bar_tab[3] = 2;
      bar_tab[4] = 5; bar_tab[5] = 4; bar_tab[6] = 1; bar_tab[7] = 0;

      vecs[0] = '{r: 5'h16, vdo: 1'b1, exp_a: 8'h66, exp_b: 8'hB5};
      vecs[1] = '{r: 5'h16, vdo: 1'b0, exp_a: 8'h00, exp_b: 8'h00};
      vecs[2] = '{r: 5'h1F, vdo: 1'b1, exp_a: 8'hFF, exp_b: 8'hFF};
      vecs[3] = '{r: 5'h0A, vdo: 1'b1, exp_a: 8'hAA, exp_b: 8'h52};
      vecs[4] = '{r: 5'h01, vdo: 1'b1, exp_a: 8'h11, exp_b: 8'h08};
      vecs[5] = '{r: 5'h10, vdo: 1'b1, exp_a: 8'h00, exp_b: 8'h84};

      // Reset state.
      rst = 1'b1; vdo = 1'b0; hsync = 1'b1; vsync = 1'b1; mode = 2'd0;
      repeat (3) tick();
      check("reset_a", {24'd0, a_r, a_bl, a_hs, a_vs}, {24'd0, 8'd0, 1'b0, 1'b1, 1'b1});
      check("reset_b", {28'd0, b_bl, b_hs, b_vs, b_mact == 2'd0}, {28'd0, 1'b0, 1'b0, 1'b0, 1'b1});

      // Latency: R=0xA appears after exactly 2 cycles (dut_a) / 3 cycles (dut_b).
      rst = 1'b0; r_in = 5'h0A; g_in = 5'h0A; b_in = 5'h0A; vdo = 1'b1;
      tick();
      check("latency_a_early", {24'd0, a_r}, 32'h00);
      tick();
      check("latency_a", {24'd0, a_r}, 32'hAA);
      check("latency_b_early", {24'd0, b_r}, 32'h00);
      tick();
      check("latency_b", {24'd0, b_r}, 32'h52);

      // Expansion / blanking table.
      for (int i = 0; i < 6; i++) begin
         r_in = vecs[i].r; g_in = vecs[i].r; b_in = vecs[i].r; vdo = vecs[i].vdo;
         repeat (3) tick();
         check("vec_a", {8'd0, a_r, a_g, a_b}, {8'd0, {3{vecs[i].exp_a}}});
         check("vec_b", {8'd0, b_r, b_g, b_b}, {8'd0, {3{vecs[i].exp_b}}});
         check("vec_blank", {31'd0, a_bl}, {31'd0, vecs[i].vdo});
      end
      vdo = 1'b0;
      repeat (4) tick();

      // Mode change mid-frame is deferred; long 96-cycle hsync pulse.
      mode = 2'd2;
      line(64, 120, 8, 96);
      check("mode_deferred", {30'd0, a_mact}, 32'd0);
      frame_start();
      check("mode_latched", {30'd0, a_mact}, 32'd2);
      for (int l = 0; l < 40; l++) line(64, 16, 4, 8);

      // Colour bars on a 640-pixel line.
      mode = 2'd1;
      frame_start();
      vdo = 1'b1;
      for (int i = 0; i < 640; i++) begin
         r_in = 5'($urandom);
         tick();
         if (i == 1)   check("bar_white",  {8'd0, a_r, a_g, a_b}, 32'hFFFFFF);
         if (i == 81)  check("bar_yellow", {8'd0, a_r, a_g, a_b}, 32'hFFFF00);
         if (i == 561) check("bar_black",  {8'd0, a_r, a_g, a_b}, 32'h000000);
      end
      vdo = 1'b0;
      repeat (40) tick();

      // Saturation of the pixel counter.
      vdo = 1'b1;
      repeat (5000) tick();
      check("saturated_black", {8'd0, a_r, a_g, a_b}, 32'h000000);
      vdo = 1'b0;
      repeat (10) tick();

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 7) == 0) vdo = ~vdo;
         vsync = ($urandom_range(0, 39) != 0);
         hsync = ($urandom_range(0, 9) != 0);
         mode  = 2'($urandom);
         r_in  = 5'($urandom); g_in = 5'($urandom); b_in = 5'($urandom);
         tick();
      end
      rst = 1'b0;
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
